serial_subtractor_ctrl: RTL and testbench

//  Bit-serial N-bit subtractor: sequences one shared full_subtractor_b cell
//  LSB-first over WIDTH cycles, computing diff = a - b - bin_init.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 11 +
 rtl/serial_subtractor_ctrl_if.sv | 31 +++
 rtl/serial_subtractor_ctrl_fs.sv | 14 +
 rtl/serial_subtractor_ctrl.sv | 98 +++++++++
 tb/tb_serial_subtractor_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Package shared by the serial subtractor controller and its users.
// Holds the controller FSM state encoding.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor.
//   start    : request, sampled only while the controller is idle
//   a, b     : minuend / subtrahend, captured on an accepted start
//   bin_init : initial borrow-in, captured on an accepted start
//   busy     : high while an operation is in flight (RUN or DONE)
//   done     : one-cycle pulse, diff/bout valid
//   diff     : result, held until the next completion
//   bout     : borrow out of the MSB (unsigned underflow flag)
// master drives the request side, slave is the controller.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin_init,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin_init,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_ctrl_fs.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
//   a, b, bin : operand bits and borrow-in
//   diff      : difference bit
//   bout      : borrow-out
module full_subtractor_b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor_b cell is walked
// LSB-first over WIDTH cycles, computing diff = a - b - bin_init.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : request/result bundle (slave side), see serial_subtractor_ctrl_if
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   sa_q, sb_q, sdiff_q;
  logic               brw_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;

  logic               cell_diff, cell_bout;
  logic               last_bit;
  logic [WIDTH-1:0]   sdiff_next;

  full_subtractor_b u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (brw_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign last_bit   = (state_q == S_RUN) && (count_q == CNT_W'(WIDTH - 1));
  assign sdiff_next = {cell_diff, sdiff_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The final bit is produced in the same cycle that leaves RUN, so the
  // result registers take the shifted-in value directly; the counter is not
  // advanced past WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sdiff_q <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            brw_q   <= bus.bin_init;
            count_q <= '0;
          end
        end
        S_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          sdiff_q <= sdiff_next;
          brw_q   <= cell_bout;
          if (last_bit) begin
            diff_q <= sdiff_next;
            bout_q <= cell_bout;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin_init = bin; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // scramble inputs after capture; they must not affect the op in flight
    bus.a = ~a; bus.b = ~b; bus.bin_init = ~bin;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 30);
    d  = bus.diff;
    bo = bus.bout;
  endtask

  initial begin
    logic [7:0] d;
    logic       bo;
    logic [8:0] m;
    int         lat;
    int         n;
    logic       extra_done;
    logic [7:0] corners[6];
    logic [7:0] ba[5], bb[5], bd[5];
    logic       bbin[5], bbo[5];
    int         cyc, prev, k;

    vecs[0]  = '{8'h05, 8'h01, 1'b0, 8'h04, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7]  = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vecs[8]  = '{8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1};
    vecs[9]  = '{8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0};
    vecs[10] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin_init = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].eb));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), 32'(bus.done), 32'd0);
    end

    // boundary operand grid against a 9-bit reference
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int c = 0; c < 2; c++) begin
          m = {1'b0, corners[i]} - {1'b0, corners[j]} - 9'(c);
          run_op(corners[i], corners[j], c[0], d, bo, lat);
          chk($sformatf("grid_%0h_%0h_%0d", corners[i], corners[j], c), {23'd0, bo, d}, {23'd0, m});
        end

    // random operands
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      m = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
      run_op(ra, rb, rc, d, bo, lat);
      chk($sformatf("rnd_%0h_%0h_%0d", ra, rb, rc), {23'd0, bo, d}, {23'd0, m});
    end

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    bus.a = 8'h37; bus.b = 8'h12; bus.bin_init = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    n = 4;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 32'(n), 32'(W + 1));
    chk("ign_diff", 32'(bus.diff), 32'h25);
    chk("ign_bout", 32'(bus.bout), 32'd0);
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    extra_done = 1'b0;
    repeat (12) begin
      if (bus.done || bus.busy) extra_done = 1'b1;
      @(negedge clk);
    end
    chk("ign_no_second_op", 32'(extra_done), 32'd0);
    chk("ign_diff_hold", 32'(bus.diff), 32'h25);

    // asynchronous reset in RUN cycle 4
    bus.a = 8'h40; bus.b = 8'h01; bus.bin_init = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_diff", 32'(bus.diff), 32'd0);
    chk("arst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h40, 8'h01, 1'b0, d, bo, lat);
    chk("post_rst_lat", 32'(lat), 32'(W + 1));
    chk("post_rst_diff", 32'(d), 32'h3F);
    chk("post_rst_bout", 32'(bo), 32'd0);

    // back-to-back with start held high
    ba = '{8'h05, 8'h00, 8'h80, 8'hA5, 8'h5A};
    bb = '{8'h01, 8'h01, 8'h80, 8'h5A, 8'hA5};
    bbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bd = '{8'h04, 8'hFF, 8'hFF, 8'h4B, 8'hB5};
    bbo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    bus.a = ba[0]; bus.b = bb[0]; bus.bin_init = bbin[0]; bus.start = 1'b1;
    cyc = 0; prev = 0; k = 0;
    while (k < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        chk($sformatf("b2b%0d_gap", k), 32'(cyc - prev), (k == 0) ? 32'(W + 1) : 32'(W + 2));
        chk($sformatf("b2b%0d_diff", k), 32'(bus.diff), 32'(bd[k]));
        chk($sformatf("b2b%0d_bout", k), 32'(bus.bout), 32'(bbo[k]));
        prev = cyc;
        k++;
        if (k < 5) begin
          bus.a = ba[k]; bus.b = bb[k]; bus.bin_init = bbin[k];
        end else begin
          bus.start = 1'b0;
        end
      end else if (k > 0) begin
        chk($sformatf("b2b_hold_c%0d", cyc), {23'd0, bus.bout, bus.diff}, {23'd0, bbo[k-1], bd[k-1]});
      end
    end
    chk("b2b_ops_completed", 32'(k), 32'd5);
    bus.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
